// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int lanes(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x W word storage: byte-enabled synchronous write, combinational read, zero at power-up.
module dmem_array
    import mem_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         idx,
    input  logic [W-1:0]          wdata,
    input  logic [lanes(W)-1:0]   be,
    output logic [W-1:0]          rdata
);

    localparam int NB = lanes(W);

    logic [W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY cycles,
// then holds the response until consumed. Handshakes: a transfer happens on the
// clock edge where valid and ready are both 1; the response fields are stable while
// rsp_valid=1 and rsp_ready=0.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int W       = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [W-1:0]          req_addr,
    input  logic [W-1:0]          req_wdata,
    input  logic [lanes(W)-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [W-1:0]          rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB = lanes(W);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rdy_en;
    logic               we_q;
    logic               err_q;
    logic [AW-1:0]      idx_q;
    logic [W-1:0]       wdata_q;
    logic [NB-1:0]      be_q;

    logic               accept;
    logic               addr_err;
    logic               enter_resp;
    logic               live;
    logic               eff_we;
    logic               eff_err;
    logic [AW-1:0]      eff_idx;
    logic [W-1:0]       eff_wdata;
    logic [NB-1:0]      eff_be;
    logic               mem_we;
    logic [W-1:0]       rd_word;

    // rdy_en keeps req_ready low until the first edge after reset release.
    assign req_ready = rdy_en && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // Full-width range check: high address bits must not alias into storage.
    assign addr_err = (req_addr[1:0] != 2'b00) ||
                      (64'(req_addr[W-1:2]) >= 64'(DEPTH));

    assign enter_resp = ((state == IDLE) && accept && (LATENCY == 0)) ||
                        ((state == BUSY) && (cnt == '0));

    // With zero latency the commit edge is the accept edge, so use the live inputs.
    assign live      = (state == IDLE);
    assign eff_we    = live ? req_we            : we_q;
    assign eff_err   = live ? addr_err          : err_q;
    assign eff_idx   = live ? req_addr[AW+1:2]  : idx_q;
    assign eff_wdata = live ? req_wdata         : wdata_q;
    assign eff_be    = live ? req_be            : be_q;
    assign mem_we    = enter_resp && eff_we && !eff_err;

    dmem_array #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (eff_idx),
        .wdata (eff_wdata),
        .be    (eff_be),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_en    <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        err_q   <= addr_err;
                        idx_q   <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_err   <= eff_err;
                rsp_rdata <= (eff_err || eff_we) ? '0 : rd_word;
            end
        end
    end

endmodule
